// File: rtl/fan_driver.sv
// Fan motor driver: spin-up kick, rate-limited speed ramp, tach stall detection
// with timed retry, and 8-level PWM generation.
module fan_driver #(
   parameter int RAMP_DIV  = 4,
   parameter int KICK_LEN  = 16,
   parameter int STALL_LIM = 64,
   parameter int RETRY_LEN = 128
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] CRS,
   input  logic       TACH,
   output logic       PWM,
   output logic [3:0] SPEED,
   output logic       RAMPING,
   output logic       STALL
);

   localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int KW = $clog2(KICK_LEN + 1);
   localparam int SW = $clog2(STALL_LIM + 1);
   localparam int FW = $clog2(RETRY_LEN + 1);

   typedef enum logic [1:0] {IDLE, KICK, RUN, FAULT} state_t;

   state_t        state_reg, state_next;
   logic [3:0]    speed_reg, speed_next;
   logic [RW-1:0] ramp_reg,  ramp_next;
   logic [KW-1:0] kick_reg,  kick_next;
   logic [SW-1:0] stall_reg, stall_next;
   logic [FW-1:0] retry_reg, retry_next;
   logic [2:0]    pwm_cnt_reg;
   logic [1:0]    tach_sync_reg;
   logic          tach_prev_reg;

   logic [3:0]    target;
   logic          tach_edge;

   assign target    = (CRS > 4'd8) ? 4'd8 : CRS;
   assign tach_edge = tach_sync_reg[1] & ~tach_prev_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         speed_reg     <= 4'd0;
         ramp_reg      <= '0;
         kick_reg      <= '0;
         stall_reg     <= '0;
         retry_reg     <= '0;
         pwm_cnt_reg   <= 3'd0;
         tach_sync_reg <= 2'b00;
         tach_prev_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         speed_reg     <= speed_next;
         ramp_reg      <= ramp_next;
         kick_reg      <= kick_next;
         stall_reg     <= stall_next;
         retry_reg     <= retry_next;
         pwm_cnt_reg   <= pwm_cnt_reg + 3'd1;
         tach_sync_reg <= {tach_sync_reg[0], TACH};
         tach_prev_reg <= tach_sync_reg[1];
      end
   end

   always_comb begin
      state_next = state_reg;
      speed_next = speed_reg;
      ramp_next  = ramp_reg;
      kick_next  = kick_reg;
      stall_next = stall_reg;
      retry_next = retry_reg;
      case (state_reg)
         IDLE: begin
            speed_next = 4'd0;
            if (target != 4'd0) begin
               state_next = KICK;
               speed_next = 4'd8;
               kick_next  = '0;
            end
         end
         KICK: begin
            speed_next = 4'd8;
            if (target == 4'd0) begin
               state_next = IDLE;
               speed_next = 4'd0;
            end else if (kick_reg == KW'(KICK_LEN - 1)) begin
               state_next = RUN;
               speed_next = target;
               stall_next = '0;
               ramp_next  = '0;
            end else begin
               kick_next = kick_reg + 1'b1;
            end
         end
         RUN: begin
            // A tach edge on the limit cycle clears the counter instead of faulting.
            if (speed_reg == 4'd0) begin
               state_next = IDLE;
               ramp_next  = '0;
            end else if (!tach_edge && stall_reg == SW'(STALL_LIM - 1)) begin
               state_next = FAULT;
               speed_next = 4'd0;
               retry_next = '0;
               ramp_next  = '0;
            end else begin
               stall_next = tach_edge ? '0 : stall_reg + 1'b1;
               if (speed_reg == target) begin
                  ramp_next = '0;
               end else if (ramp_reg == RW'(RAMP_DIV - 1)) begin
                  ramp_next  = '0;
                  speed_next = (target > speed_reg) ? speed_reg + 4'd1 : speed_reg - 4'd1;
               end else begin
                  ramp_next = ramp_reg + 1'b1;
               end
            end
         end
         FAULT: begin
            speed_next = 4'd0;
            if (retry_reg == FW'(RETRY_LEN - 1)) begin
               if (target != 4'd0) begin
                  state_next = KICK;
                  speed_next = 4'd8;
                  kick_next  = '0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               retry_next = retry_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            speed_next = 4'd0;
         end
      endcase
   end

   assign SPEED   = speed_reg;
   assign PWM     = (speed_reg == 4'd8) | ({1'b0, pwm_cnt_reg} < speed_reg);
   assign RAMPING = (state_reg == RUN) && (speed_reg != target);
   assign STALL   = (state_reg == FAULT);

endmodule

// File: tb/tb_fan_driver.sv
// Self-checking bench for fan_driver: vector table for kick/run/PWM levels,
// plus hand sequences for ramp, stall, tach race and asynchronous reset.
module tb_fan_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] CRS = 4'd0;
   wire        TACH;
   logic       PWM;
   logic [3:0] SPEED;
   logic       RAMPING;
   logic       STALL;

   logic tach_en   = 1'b0;
   logic tach_auto = 1'b0;
   logic tach_man  = 1'b0;
   assign TACH = tach_en ? tach_auto : tach_man;

   int n_cmp = 0;
   int n_bad = 0;

   fan_driver dut (
      .clk(clk), .rst(rst), .CRS(CRS), .TACH(TACH),
      .PWM(PWM), .SPEED(SPEED), .RAMPING(RAMPING), .STALL(STALL)
   );

   always #5 clk = ~clk;

   // Free-running tach: toggles every 10 cycles, away from both clock edges.
   initial begin
      forever begin
         repeat (10) @(posedge clk);
         #3 tach_auto = ~tach_auto;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      CRS      = 4'd0;
      tach_en  = 1'b0;
      tach_man = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic count_pwm(output int hi);
      hi = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (PWM) hi++;
      end
   endtask

   typedef struct {
      logic [3:0] crs;
      int         kick_speed;
      int         run_speed;
      int         pwm_hi;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int hi, cnt, bad_pwm, exp_s;

      vecs[0] = '{4'd1,  8, 1, 1};
      vecs[1] = '{4'd3,  8, 3, 3};
      vecs[2] = '{4'd4,  8, 4, 4};
      vecs[3] = '{4'd7,  8, 7, 7};
      vecs[4] = '{4'd8,  8, 8, 8};
      vecs[5] = '{4'd12, 8, 8, 8};
      vecs[6] = '{4'd15, 8, 8, 8};
      vecs[7] = '{4'd0,  0, 0, 0};

      // Reset state, checked while rst is held and before any clock edge
      #1;
      chk("reset_speed",   SPEED,   0);
      chk("reset_pwm",     PWM,     0);
      chk("reset_ramping", RAMPING, 0);
      chk("reset_stall",   STALL,   0);

      // Vector table: kick level, settled run level, PWM duty
      for (int v = 0; v < 8; v++) begin
         do_reset();
         tach_en = 1'b1;
         CRS = vecs[v].crs;
         repeat (16) tick();
         chk("vec_kick_speed", SPEED, vecs[v].kick_speed);
         tick();
         chk("vec_run_speed", SPEED, vecs[v].run_speed);
         count_pwm(hi);
         chk("vec_pwm_hi", hi, vecs[v].pwm_hi);
         chk("vec_ramping", RAMPING, 0);
         $display("vec %0d crs=%0d speed=%0d pwm_hi=%0d", v, vecs[v].crs, SPEED, hi);
      end

      // Start: kick lasts exactly 16 cycles at full duty, then SPEED=4
      do_reset();
      tach_en = 1'b1;
      CRS = 4'd4;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (SPEED == 4'd8 && PWM) cnt++;
      end
      chk("start_kick_cycles", cnt, 16);
      tick();
      chk("start_run_speed", SPEED, 4);
      count_pwm(hi);
      chk("start_pwm_hi", hi, 4);
      $display("start: kick_cycles=%0d run_speed=%0d pwm_hi=%0d", cnt, SPEED, hi);

      // Ramp up 4 -> 8, one step per 4 cycles
      CRS = 4'd8;
      for (int t = 1; t <= 16; t++) begin
         tick();
         exp_s = 4 + t / 4;
         chk("ramp_up_speed", SPEED, exp_s);
         chk("ramp_up_ramping", RAMPING, (exp_s != 8) ? 1 : 0);
      end
      $display("ramp up: speed=%0d ramping=%0d", SPEED, RAMPING);

      // Ramp down 8 -> 0, then the FSM must be back in IDLE
      CRS = 4'd0;
      for (int t = 1; t <= 32; t++) begin
         tick();
         exp_s = 8 - t / 4;
         chk("ramp_dn_speed", SPEED, exp_s);
         chk("ramp_dn_ramping", RAMPING, (exp_s != 0) ? 1 : 0);
      end
      CRS = 4'd3;
      tick();
      chk("ramp_dn_run_to_idle", SPEED, 0);
      tick();
      chk("ramp_dn_idle_to_kick", SPEED, 8);
      $display("ramp down: reached 0, re-kick speed=%0d", SPEED);

      // Stall: tach held low from kick start; fault after 64 RUN cycles
      do_reset();
      CRS = 4'd6;
      repeat (17) tick();
      chk("stall_run_speed", SPEED, 6);
      repeat (63) tick();
      chk("stall_pre_limit", STALL, 0);
      chk("stall_pre_speed", SPEED, 6);
      tick();
      chk("stall_fault_enter", STALL, 1);
      chk("stall_fault_speed", SPEED, 0);
      cnt = 1;
      bad_pwm = (PWM || RAMPING) ? 1 : 0;
      for (int k = 1; k < 128; k++) begin
         if (k == 10) CRS = 4'd0;
         if (k == 20) CRS = 4'd6;
         tick();
         if (STALL) cnt++;
         if (PWM || RAMPING) bad_pwm++;
      end
      chk("stall_fault_cycles", cnt, 128);
      chk("stall_fault_pwm_low", bad_pwm, 0);
      tick();
      chk("stall_retry_stall", STALL, 0);
      chk("stall_retry_kick", SPEED, 8);
      $display("stall: fault_cycles=%0d retry_speed=%0d", cnt, SPEED);

      // Race: tach edge lands on the limit cycle; counter restarts from 0
      do_reset();
      CRS = 4'd6;
      repeat (17) tick();
      chk("race_run_speed", SPEED, 6);
      repeat (61) tick();
      tach_man = 1'b1;
      repeat (3) tick();
      chk("race_no_fault", STALL, 0);
      repeat (63) tick();
      chk("race_restart_pre", STALL, 0);
      tick();
      chk("race_restart_fault", STALL, 1);
      $display("race: late fault stall=%0d", STALL);

      // Asynchronous reset mid-ramp at SPEED=6, then clean restart
      do_reset();
      tach_en = 1'b1;
      CRS = 4'd3;
      repeat (17) tick();
      CRS = 4'd8;
      for (int i = 0; i < 40 && SPEED != 4'd6; i++) tick();
      chk("areset_mid_speed", SPEED, 6);
      #2 rst = 1'b1;
      #1;
      chk("areset_speed",   SPEED,   0);
      chk("areset_pwm",     PWM,     0);
      chk("areset_ramping", RAMPING, 0);
      chk("areset_stall",   STALL,   0);
      tick();
      rst = 1'b0;
      CRS = 4'd5;
      tick();
      chk("areset_rekick", SPEED, 8);
      repeat (15) tick();
      chk("areset_kick_end", SPEED, 8);
      tick();
      chk("areset_run", SPEED, 5);
      $display("areset: restart run speed=%0d", SPEED);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
